db_tick_fsm: RTL and testbench

Debouncer for one mechanical pushbutton or switch. It produces a clean level, one-cycle rise and fall ticks, and a saturating count of rejected bounce episodes. It sits directly upstream of the button-driven counter/display logic: `db_level` and `db_rise` feed its edge-counting datapath, and `bounce_cnt` can be routed to a hex display digit pair.

---
 rtl/db_tick_fsm_pkg.sv | 12 +
 rtl/db_tick_fsm_if.sv | 21 ++
 rtl/db_tick_fsm_sync_2ff.sv | 21 ++
 rtl/db_tick_fsm.sv | 116 +++++++++++
 tb/tb_db_tick_fsm.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/db_tick_fsm_pkg.sv
// Shared types and default sizes for the pushbutton debouncer.
package db_pkg;
    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_t;

    localparam int DB_N_DEFAULT  = 19;
    localparam int DB_CW_DEFAULT = 8;
endpackage

// File: rtl/db_tick_fsm_if.sv
// Button-side bundle: raw input and clear in, debounced level, ticks and bounce count out.
interface db_tick_fsm_if #(
    parameter int CW = db_pkg::DB_CW_DEFAULT
);
    logic          sw;
    logic          clr;
    logic          db_level;
    logic          db_rise;
    logic          db_fall;
    logic [CW-1:0] bounce_cnt;

    modport master (
        output sw, clr,
        input  db_level, db_rise, db_fall, bounce_cnt
    );

    modport slave (
        input  sw, clr,
        output db_level, db_rise, db_fall, bounce_cnt
    );
endinterface

// File: rtl/db_tick_fsm_sync_2ff.sv
// Two-flop synchronizer for the raw switch; only built when DB_SYNC_EN is defined.
`ifdef DB_SYNC_EN
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);
    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];
endmodule
`endif

// File: rtl/db_tick_fsm.sv
// Debouncer FSM: qualifies 2^N+1 stable samples per transition, emits ticks, counts aborts.
// DB_SYNC_EN adds a 2-flop synchronizer in front of the sampled input.
module db_tick_fsm
    import db_pkg::*;
#(
    parameter int N  = DB_N_DEFAULT,
    parameter int CW = DB_CW_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    db_tick_fsm_if.slave bus
);
    localparam logic [N-1:0]  Q_LOAD  = '1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          w_sw_s;
    db_state_t     r_state, w_state_next;
    logic [N-1:0]  r_q, w_q_next;
    logic          r_level, w_level_next;
    logic          r_rise, w_rise_next;
    logic          r_fall, w_fall_next;
    logic          w_abort;
    logic [CW-1:0] r_cnt, w_cnt_next;

`ifdef DB_SYNC_EN
    sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (bus.sw),
        .o_q     (w_sw_s)
    );
`else
    assign w_sw_s = bus.sw;
`endif

    // A level change in a WAIT state aborts even when q has reached zero.
    always_comb begin
        w_state_next = r_state;
        w_q_next     = r_q;
        w_rise_next  = 1'b0;
        w_fall_next  = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ZERO: begin
                if (w_sw_s) begin
                    w_state_next = WAIT1;
                    w_q_next     = Q_LOAD;
                end
            end
            WAIT1: begin
                if (!w_sw_s) begin
                    w_state_next = ZERO;
                    w_abort      = 1'b1;
                end else if (r_q == '0) begin
                    w_state_next = ONE;
                    w_rise_next  = 1'b1;
                end else begin
                    w_q_next = r_q - N'(1);
                end
            end
            ONE: begin
                if (!w_sw_s) begin
                    w_state_next = WAIT0;
                    w_q_next     = Q_LOAD;
                end
            end
            WAIT0: begin
                if (w_sw_s) begin
                    w_state_next = ONE;
                    w_abort      = 1'b1;
                end else if (r_q == '0) begin
                    w_state_next = ZERO;
                    w_fall_next  = 1'b1;
                end else begin
                    w_q_next = r_q - N'(1);
                end
            end
            default: begin
                w_state_next = ZERO;
            end
        endcase

        w_level_next = (w_state_next == ONE) || (w_state_next == WAIT0);

        if (bus.clr) begin
            w_cnt_next = '0;
        end else if (w_abort && (r_cnt != CNT_MAX)) begin
            w_cnt_next = r_cnt + CW'(1);
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ZERO;
            r_q     <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_q     <= w_q_next;
            r_level <= w_level_next;
            r_rise  <= w_rise_next;
            r_fall  <= w_fall_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign bus.db_level   = r_level;
    assign bus.db_rise    = r_rise;
    assign bus.db_fall    = r_fall;
    assign bus.bounce_cnt = r_cnt;
endmodule

// File: tb/tb_db_tick_fsm.sv
// Scoreboard bench for db_tick_fsm with N=3, CW=4: expected tick/count events are queued
// by the stimulus and matched by a negedge monitor.
module tb_db_tick_fsm;
`ifdef DB_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif
    localparam int K_RISE = 1;
    localparam int K_FALL = 2;
    localparam int K_CNT  = 3;

    typedef struct {
        int kind;
        int at_edge;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    db_tick_fsm_if #(.CW(4)) bus ();

    db_tick_fsm #(.N(3), .CW(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    ev_t        exp_q[$];
    int         edge_no  = 0;
    int         n_vec    = 0;
    int         n_err    = 0;
    logic [3:0] prev_cnt = 4'd0;

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic expect_ev(input int kind, input int at, input int val);
        ev_t e;
        e.kind    = kind;
        e.at_edge = at + L;
        e.val     = val;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic s, input logic c);
        bus.sw  = s;
        bus.clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic observe(input int kind, input int val);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: kind %0d val %0d at edge %0d, none required",
                     kind, val, edge_no);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.at_edge != edge_no || e.val != val) begin
                n_err++;
                $display("FAIL event: got kind %0d val %0d at edge %0d, required kind %0d val %0d at edge %0d",
                         kind, val, edge_no, e.kind, e.val, e.at_edge);
            end else begin
                $display("ok   event kind %0d val %0d at edge %0d", kind, val, edge_no);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_cnt = bus.bounce_cnt;
        end else begin
            if (bus.db_rise && bus.db_fall) begin
                n_vec++;
                n_err++;
                $display("FAIL both_ticks: rise and fall both 1 at edge %0d, required at most one", edge_no);
            end
            if (bus.db_rise) observe(K_RISE, int'(bus.db_level));
            if (bus.db_fall) observe(K_FALL, int'(bus.db_level));
            if (bus.bounce_cnt != prev_cnt) observe(K_CNT, int'(bus.bounce_cnt));
            prev_cnt = bus.bounce_cnt;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        bus.sw  = 1'b0;
        bus.clr = 1'b0;
        reset_n = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        check("rst_level", int'(bus.db_level), 0);
        check("rst_rise", int'(bus.db_rise), 0);
        check("rst_fall", int'(bus.db_fall), 0);
        check("rst_cnt", int'(bus.bounce_cnt), 0);
        reset_n = 1'b1;
        repeat (2) step(1'b0, 1'b0);

        // clean press: rise after the 9th high sample
        k = edge_no + 1;
        expect_ev(K_RISE, k + 8, 1);
        repeat (20) step(1'b1, 1'b0);
        check("press_level", int'(bus.db_level), 1);
        check("press_cnt", int'(bus.bounce_cnt), 0);

        // clean release
        k = edge_no + 1;
        expect_ev(K_FALL, k + 8, 0);
        repeat (12) step(1'b0, 1'b0);
        check("release_level", int'(bus.db_level), 0);

        // bounce 1,1,1,0 then held high
        k = edge_no + 1;
        expect_ev(K_CNT, k + 3, 1);
        expect_ev(K_RISE, k + 12, 1);
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        repeat (12) step(1'b1, 1'b0);

        // glitch 0,1 while in ONE: aborted release
        k = edge_no + 1;
        expect_ev(K_CNT, k + 1, 2);
        step(1'b0, 1'b0);
        repeat (11) step(1'b1, 1'b0);
        check("glitch_level", int'(bus.db_level), 1);

        k = edge_no + 1;
        expect_ev(K_FALL, k + 8, 0);
        repeat (12) step(1'b0, 1'b0);

        // 20 aborts saturate the count at 15
        k = edge_no + 1;
        for (int i = 0; i < 20; i++) begin
            if (3 + i <= 15) expect_ev(K_CNT, k + 2 * i + 1, 3 + i);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        repeat (4) step(1'b0, 1'b0);
        check("sat_cnt", int'(bus.bounce_cnt), 15);

        // clr in the same cycle as an abort wins (from 15, then from 1)
        for (int pass = 0; pass < 2; pass++) begin
            k = edge_no + 1;
            expect_ev(K_CNT, k + 1, 0);
            step(1'b1, 1'b0);
            for (int j = 0; j <= L; j++) step(1'b0, (j == L) ? 1'b1 : 1'b0);
            repeat (3) step(1'b0, 1'b0);
            if (pass == 0) begin
                k = edge_no + 1;
                expect_ev(K_CNT, k + 1, 1);
                step(1'b1, 1'b0);
                repeat (4) step(1'b0, 1'b0);
            end
        end
        check("clr_cnt", int'(bus.bounce_cnt), 0);

        // reset mid-WAIT1 at q=2, then full requalification with clr held
        repeat (6) step(1'b1, 1'b0);
        reset_n = 1'b0;
        step(1'b1, 1'b0);
        check("midrst_level", int'(bus.db_level), 0);
        check("midrst_rise", int'(bus.db_rise), 0);
        reset_n = 1'b1;
        k = edge_no + 1;
        expect_ev(K_RISE, k + 8, 1);
        repeat (12) step(1'b1, 1'b1);
        check("requal_level", int'(bus.db_level), 1);
        k = edge_no + 1;
        expect_ev(K_FALL, k + 8, 0);
        repeat (12) step(1'b0, 1'b0);

        repeat (10) step(1'b0, 1'b0);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
